prg_mem_responder: RTL and testbench

Program-memory responder for the monitor's `prg_*` access port. It owns a 2^ADDR_W × DATA_W program memory and serves monitor reads and writes, each strobed by the monitor's software-toggled `prg_clock` line. It also serves instruction fetches from the CPU core. It sits between the monitor system and the CPU datapath, and is gated by the monitor's CPU-hold (reset) output.

---
 rtl/prg_mem_responder.sv | 150 +++++++++++++++
 tb/tb_prg_mem_responder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/prg_mem_responder.sv
// prg_mem_responder: program memory shared between the monitor prg_* port
// (strobed by a software-toggled prg_clock) and CPU instruction fetch.
// Optional feature macro: PRG_MEM_CLEAR_EN adds a post-reset clear sweep
// (CLEAR state) that zeroes every entry before monitor access is served.
module prg_mem_responder #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic              prg_clock,
    input  logic [ADDR_W-1:0] prg_ma,
    input  logic [DATA_W-1:0] prg_wd,
    input  logic              prg_we,
    output logic [DATA_W-1:0] prg_rd,
    input  logic              cpu_hold,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic [DATA_W-1:0] cpu_data,
    output logic              busy,
    output logic [7:0]        prg_wr_count,
    output logic              prg_err
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = 8;

    logic [DATA_W-1:0]      mem_q [DEPTH];
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   sync_out;
    logic                   strobe_edge;
    logic                   clearing;
    logic                   mon_wr;
    logic                   mon_rd;
    logic                   mon_rej;
    logic [DATA_W-1:0]      prg_rd_q;
    logic [DATA_W-1:0]      cpu_data_q;
    logic [CNT_W-1:0]       wr_count_q;
    logic                   err_q;

`ifdef PRG_MEM_CLEAR_EN
    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_IDLE  = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
    logic              busy_q;

    // Next-state logic: walk the clear pointer once, then settle in IDLE
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        if (state_q == ST_CLEAR) begin
            clr_ptr_d = clr_ptr_q + ADDR_W'(1);
            if (clr_ptr_q == {ADDR_W{1'b1}}) begin
                state_d = ST_IDLE;
            end
        end
    end

    // FSM state, clear pointer and busy flag; reset restarts the sweep at 0
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q   <= ST_CLEAR;
            clr_ptr_q <= '0;
            busy_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            busy_q    <= (state_d == ST_CLEAR);
        end
    end

    assign clearing = (state_q == ST_CLEAR);
    assign busy     = busy_q;
`else
    assign clearing = 1'b0;
    assign busy     = 1'b0;
`endif

    // prg_clock synchronizer plus previous-value flop; all preset to 1 so a
    // line held high through reset never looks like a rising edge
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], prg_clock};
            prev_q <= sync_out;
        end
    end

    assign sync_out    = sync_q[SYNC_STAGES-1];
    assign strobe_edge = sync_out & ~prev_q;
    assign mon_wr  = strobe_edge & ~clearing & prg_we & cpu_hold & ~reset_reset;
    assign mon_rd  = strobe_edge & ~clearing & ~mon_wr;
    assign mon_rej = strobe_edge & prg_we & (clearing | ~cpu_hold);

    // Memory array: clear sweep writes zero, otherwise accepted monitor writes
    always_ff @(posedge clk_clk) begin
`ifdef PRG_MEM_CLEAR_EN
        if (clearing) begin
            mem_q[clr_ptr_q] <= '0;
        end else if (mon_wr) begin
            mem_q[prg_ma] <= prg_wd;
        end
`else
        if (mon_wr) begin
            mem_q[prg_ma] <= prg_wd;
        end
`endif
    end

    // Monitor read data, write counter and sticky reject flag
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            prg_rd_q   <= '0;
            wr_count_q <= '0;
            err_q      <= 1'b0;
        end else begin
            if (mon_wr) begin
                prg_rd_q   <= prg_wd;
                wr_count_q <= wr_count_q + CNT_W'(1);
            end else if (mon_rd) begin
                prg_rd_q <= mem_q[prg_ma];
            end
            if (mon_rej) begin
                err_q <= 1'b1;
            end
        end
    end

    // CPU fetch port: read-first registered read, forced to zero while clearing
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            cpu_data_q <= '0;
        end else if (clearing) begin
            cpu_data_q <= '0;
        end else begin
            cpu_data_q <= mem_q[cpu_addr];
        end
    end

    assign prg_rd       = prg_rd_q;
    assign cpu_data     = cpu_data_q;
    assign prg_wr_count = wr_count_q;
    assign prg_err      = err_q;

endmodule

// File: tb/tb_prg_mem_responder.sv
// Self-checking bench for prg_mem_responder (ADDR_W=8, DATA_W=8, SYNC_STAGES=2).
// Works with or without PRG_MEM_CLEAR_EN defined.
module tb_prg_mem_responder;

    logic       clk_clk = 1'b0;
    logic       reset_reset;
    logic       prg_clock;
    logic [7:0] prg_ma;
    logic [7:0] prg_wd;
    logic       prg_we;
    logic [7:0] prg_rd;
    logic       cpu_hold;
    logic [7:0] cpu_addr;
    logic [7:0] cpu_data;
    logic       busy;
    logic [7:0] prg_wr_count;
    logic       prg_err;

    int chk_cnt  = 0;
    int pass_cnt = 0;

`ifdef PRG_MEM_CLEAR_EN
    localparam logic EXP_BUSY_RST = 1'b1;
`else
    localparam logic EXP_BUSY_RST = 1'b0;
`endif

    typedef struct {
        logic       we;
        logic       hold;
        logic [7:0] ma;
        logic [7:0] wd;
        logic [7:0] exp_rd;
        logic [7:0] exp_cnt;
        logic       exp_err;
        logic [7:0] exp_cpu;
    } vec_t;

    vec_t vecs [8];

    prg_mem_responder #(.ADDR_W(8), .DATA_W(8), .SYNC_STAGES(2)) dut (
        .clk_clk      (clk_clk),
        .reset_reset  (reset_reset),
        .prg_clock    (prg_clock),
        .prg_ma       (prg_ma),
        .prg_wd       (prg_wd),
        .prg_we       (prg_we),
        .prg_rd       (prg_rd),
        .cpu_hold     (cpu_hold),
        .cpu_addr     (cpu_addr),
        .cpu_data     (cpu_data),
        .busy         (busy),
        .prg_wr_count (prg_wr_count),
        .prg_err      (prg_err)
    );

    always #5 clk_clk = ~clk_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Full-length monitor strobe: inputs stable, prg_clock high 4 then low 4 cycles
    task automatic strobe(input logic we, input logic hold, input logic [7:0] ma, input logic [7:0] wd);
        prg_we   = we;
        cpu_hold = hold;
        prg_ma   = ma;
        prg_wd   = wd;
        @(negedge clk_clk);
        prg_clock = 1'b1;
        repeat (4) @(negedge clk_clk);
        prg_clock = 1'b0;
        repeat (4) @(negedge clk_clk);
    endtask

    // Count cycles busy stays high from now (called at the release negedge)
    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 1000) begin
            n++;
            @(negedge clk_clk);
        end
    endtask

    initial begin
        int n;
        logic [7:0] cnt_before;

        reset_reset = 1'b1;
        prg_clock   = 1'b0;
        prg_ma      = '0;
        prg_wd      = '0;
        prg_we      = 1'b0;
        cpu_hold    = 1'b1;
        cpu_addr    = '0;

        vecs[0] = '{1'b1, 1'b1, 8'h3C, 8'hA5, 8'hA5, 8'd1, 1'b0, 8'hA5};
        vecs[1] = '{1'b0, 1'b1, 8'h3C, 8'h00, 8'hA5, 8'd1, 1'b0, 8'hA5};
        vecs[2] = '{1'b1, 1'b1, 8'h10, 8'h5A, 8'h5A, 8'd2, 1'b0, 8'h5A};
        vecs[3] = '{1'b1, 1'b0, 8'h10, 8'hFF, 8'h5A, 8'd2, 1'b1, 8'h5A};
        vecs[4] = '{1'b1, 1'b1, 8'hFF, 8'h11, 8'h11, 8'd3, 1'b1, 8'h11};
        vecs[5] = '{1'b0, 1'b0, 8'h10, 8'h00, 8'h5A, 8'd3, 1'b1, 8'h5A};
        vecs[6] = '{1'b1, 1'b1, 8'h00, 8'hC3, 8'hC3, 8'd4, 1'b1, 8'hC3};
        vecs[7] = '{1'b0, 1'b1, 8'hFF, 8'h00, 8'h11, 8'd4, 1'b1, 8'h11};

        // Reset values
        repeat (3) @(negedge clk_clk);
        check("rst_prg_rd", 32'(prg_rd), 32'h0);
        check("rst_cpu_data", 32'(cpu_data), 32'h0);
        check("rst_wr_count", 32'(prg_wr_count), 32'h0);
        check("rst_prg_err", 32'(prg_err), 32'h0);
        check("rst_busy", 32'(busy), 32'(EXP_BUSY_RST));

        // Release reset and measure the sweep
        reset_reset = 1'b0;
        count_busy(n);
`ifdef PRG_MEM_CLEAR_EN
        check("sweep_len", 32'(n), 32'd256);
        cpu_addr = 8'h77;
        @(negedge clk_clk);
        check("cleared_cpu_77", 32'(cpu_data), 32'h0);
        cpu_addr = 8'h3C;
        @(negedge clk_clk);
        check("cleared_cpu_3c", 32'(cpu_data), 32'h0);
`else
        check("no_sweep_len", 32'(n), 32'd0);
`endif

        // Table-driven monitor accesses
        for (int i = 0; i < 8; i++) begin
            strobe(vecs[i].we, vecs[i].hold, vecs[i].ma, vecs[i].wd);
            check($sformatf("v%0d_prg_rd", i), 32'(prg_rd), 32'(vecs[i].exp_rd));
            check($sformatf("v%0d_wr_count", i), 32'(prg_wr_count), 32'(vecs[i].exp_cnt));
            check($sformatf("v%0d_prg_err", i), 32'(prg_err), 32'(vecs[i].exp_err));
            cpu_addr = vecs[i].ma;
            @(negedge clk_clk);
            check($sformatf("v%0d_cpu_data", i), 32'(cpu_data), 32'(vecs[i].exp_cpu));
        end

        // Strobe latency and CPU read-first on a same-address write
        prg_we   = 1'b1;
        cpu_hold = 1'b1;
        prg_ma   = 8'h3C;
        prg_wd   = 8'h77;
        cpu_addr = 8'h3C;
        @(negedge clk_clk);
        prg_clock = 1'b1;
        @(negedge clk_clk);
        @(negedge clk_clk);
        check("lat_k1_prg_rd", 32'(prg_rd), 32'h11);
        check("lat_k1_wr_count", 32'(prg_wr_count), 32'd4);
        @(negedge clk_clk);
        check("lat_k2_prg_rd", 32'(prg_rd), 32'h77);
        check("lat_k2_wr_count", 32'(prg_wr_count), 32'd5);
        check("lat_k2_cpu_old", 32'(cpu_data), 32'hA5);
        @(negedge clk_clk);
        check("lat_k3_cpu_new", 32'(cpu_data), 32'h77);
        prg_clock = 1'b0;
        repeat (4) @(negedge clk_clk);

        // Counter wrap: 251 more valid writes bring the count from 5 to 0
        for (int i = 0; i < 251; i++) begin
            strobe(1'b1, 1'b1, 8'h80 + 8'(i % 64), 8'(i));
        end
        check("wrap_wr_count", 32'(prg_wr_count), 32'd0);
        check("err_sticky", 32'(prg_err), 32'h1);

        // A single-cycle pulse commits at most once
        cnt_before = prg_wr_count;
        prg_we   = 1'b1;
        cpu_hold = 1'b1;
        prg_ma   = 8'h20;
        prg_wd   = 8'h42;
        @(negedge clk_clk);
        prg_clock = 1'b1;
        @(negedge clk_clk);
        prg_clock = 1'b0;
        repeat (8) @(negedge clk_clk);
        check("pulse_le_one", 32'((8'(prg_wr_count - cnt_before)) <= 8'd1), 32'h1);

        // prg_clock held high through reset: no write afterwards
        prg_ma    = 8'h3C;
        prg_wd    = 8'hEE;
        prg_we    = 1'b1;
        cpu_hold  = 1'b1;
        prg_clock = 1'b1;
        reset_reset = 1'b1;
        repeat (3) @(negedge clk_clk);
        reset_reset = 1'b0;
        count_busy(n);
        repeat (8) @(negedge clk_clk);
        check("hi_rst_wr_count", 32'(prg_wr_count), 32'd0);
        check("hi_rst_prg_err", 32'(prg_err), 32'h0);
        check("hi_rst_prg_rd", 32'(prg_rd), 32'h0);
        cpu_addr = 8'h3C;
        @(negedge clk_clk);
`ifdef PRG_MEM_CLEAR_EN
        check("hi_rst_cpu_3c", 32'(cpu_data), 32'h0);
`else
        check("hi_rst_cpu_3c", 32'(cpu_data), 32'h77);
`endif
        prg_clock = 1'b0;
        prg_we    = 1'b0;
        repeat (4) @(negedge clk_clk);

`ifdef PRG_MEM_CLEAR_EN
        // Reset mid-sweep restarts the full sweep
        reset_reset = 1'b1;
        @(negedge clk_clk);
        reset_reset = 1'b0;
        repeat (100) @(negedge clk_clk);
        reset_reset = 1'b1;
        @(negedge clk_clk);
        reset_reset = 1'b0;
        count_busy(n);
        check("midsweep_len", 32'(n), 32'd256);
`endif

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
